// File: rtl/softmax_max_seq_if.sv
// Handshake and result bundle for the Softmax running-maximum sequencer.
// master = score buffer / consumer side, slave = the sequencer itself.
interface softmax_max_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) ();
  // Both channels use valid/ready: a transfer happens on a rising clk edge
  // where valid and ready are both high; valid never waits on ready.
  logic                  start;
  logic [LEN_WIDTH-1:0]  vec_len;
  logic                  abort;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] max_val;
  logic [LEN_WIDTH-1:0]  max_idx;
  logic                  empty;
  logic                  busy;

  modport master (
    output start, vec_len, abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, max_val, max_idx, empty, busy
  );

  modport slave (
    input  start, vec_len, abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, max_val, max_idx, empty, busy
  );
endinterface

// File: rtl/softmax_max_seq.sv
// Streams one signed vector through a compare-exchange stage and reports the
// maximum and the index of its first occurrence for the max-subtraction step.
module softmax_max_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  softmax_max_seq_if.slave     bus,
  output logic [1:0]           state_dbg
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
  logic [LEN_WIDTH-1:0]  max_idx_q, max_idx_d;
  logic                  empty_q, empty_d;
  logic                  beat;

  // Handshake outputs decode only the registered state.
  assign bus.in_ready  = (state_q == S_RUN);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.max_val   = max_val_q;
  assign bus.max_idx   = max_idx_q;
  assign bus.empty     = empty_q;
  assign state_dbg     = state_q;

  assign beat = bus.in_valid && (state_q == S_RUN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    empty_d   = empty_q;
    if (bus.abort) begin
      // Result registers keep their last values; only the sequencing resets.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            len_d = bus.vec_len;
            cnt_d = '0;
            if (bus.vec_len != '0) begin
              state_d = S_RUN;
              empty_d = 1'b0;
            end else begin
              state_d   = S_DONE;
              max_val_d = MIN_VAL;
              max_idx_d = '0;
              empty_d   = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (beat) begin
            // Strict compare keeps the earliest index on ties.
            if ((cnt_q == '0) || ($signed(bus.in_data) > $signed(max_val_q))) begin
              max_val_d = bus.in_data;
              max_idx_d = cnt_q;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      empty_q   <= empty_d;
    end
  end
endmodule

// File: doc/softmax_max_seq.md
# softmax_max_seq

Sequencing controller for the Softmax datapath: accepts a stream of signed elements for one vector, runs them one per cycle through a signed compare-exchange stage, and keeps the running major (maximum) value and its index. Reports the vector maximum for the max-subtraction step before exponentiation. Sits between the score buffer read port and the Softmax exponent unit. Uses valid/ready handshakes on input and output.

## Interface
- DATA_WIDTH, 8, element width (signed two's complement)
- LEN_WIDTH, 8, width of vector length and index
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a vector; sampled only in IDLE
- vec_len  in  LEN_WIDTH  element count, captured with start; 0 is legal
- abort  in  1  synchronous; returns to IDLE from any state
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  DATA_WIDTH  signed element
- out_valid  out  1  max_val/max_idx/empty valid
- out_ready  in  1  consumer accepts result
- max_val  out  DATA_WIDTH  signed vector maximum
- max_idx  out  LEN_WIDTH  index of maximum (first occurrence)
- empty  out  1  result belongs to a zero-length vector
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 captures vec_len and clears the element counter. If vec_len≠0, go to RUN. If vec_len=0, go to DONE with max_val = −2^(DATA_WIDTH−1), max_idx=0, empty=1.
- RUN: in_ready=1. On each beat (in_valid & in_ready):
  - Element 0 loads max_val and sets max_idx=0 unconditionally.
  - Later elements replace max_val and max_idx only when in_data > max_val (signed, strict). Ties keep the earlier index.
  - The counter increments on every beat.
  - The beat with counter = vec_len−1 moves the state to DONE.
- RUN with in_valid low: no state change. Bubbles of any length are allowed.
- DONE: out_valid=1. max_val, max_idx and empty are held stable while out_ready=0. When out_valid & out_ready, go to IDLE.
- start outside IDLE is ignored, including a start in the same cycle as the DONE handshake.
- abort (highest priority after rst): next state is IDLE and the counter clears. Outputs max_val, max_idx and empty keep their last values, and out_valid drops.
- Arithmetic: only signed comparisons. The counter is LEN_WIDTH wide. vec_len = 2^LEN_WIDTH−1 must work without overflow.
- The empty flag clears when start is accepted with a nonzero vec_len.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, max_val=0, max_idx=0, empty=0, state IDLE.
- in_ready, out_valid and busy are decoded from the registered state only. There is no combinational path from in_valid or out_ready.
- in_ready rises in the cycle after start is accepted.
- Latency: if the last beat is accepted at edge k, then out_valid=1 and the final max_val/max_idx are visible from edge k. in_ready=0 in the same cycle.
- Zero-length vector: out_valid rises in the cycle after start.
- Throughput: 1 element/cycle. A vector of N elements with continuous in_valid and an immediate out_ready takes N+2 cycles from start to the next start opportunity.
- rst assertion mid-vector clears everything immediately (asynchronous). Deassertion is synchronous to clk at the bench.

## Test plan
- Basic vector: vec_len=4, data 12, 1, −3, 5 streamed continuously -> out_valid 4 cycles after in_ready rises; max_val=12, max_idx=0, empty=0.
- All-negative vector with ties: vec_len=5, data −7, −3, −9, −3, −128 -> max_val=−3, max_idx=1 (first occurrence).
- Bubbles and backpressure: vec_len=3, data 6, 1, 6 with in_valid low for 2 cycles between beats; out_ready held low for 5 cycles -> outputs stable until the handshake; max_val=6, max_idx=0; busy deasserts the cycle after the handshake.
- Zero length: start with vec_len=0 -> next cycle out_valid=1, empty=1, max_val=−128, max_idx=0; in_ready never asserts.
- Abort and restart: vec_len=8, abort after 3 beats -> IDLE next cycle with out_valid=0. Then a new start with vec_len=2, data 5, 127 -> max_val=127, max_idx=1. A start pulsed during RUN has no effect.
- Reset mid-operation: assert rst during RUN -> all outputs at reset values immediately. After release, a vec_len=1, data −1 vector -> max_val=−1, max_idx=0.
